hw_status_logger: RTL and testbench
===================================

// Module: hw_status_logger
// PURPOSE
//   PS-side receiver for the hardware manager's status/interrupt output. Captures the
//   status_word on every ps_interrupt event, timestamps it, and queues the record in a
//   FWFT FIFO for software to pop. Provides a level IRQ, sticky overflow, saturating drop
//   count and the last captured status word. Sits between the hardware manager and the
//   PS register/interrupt fabric.
// PARAMETERS
//   DEPTH     16  FIFO entries; must be a power of 2, >= 2
//   TS_WIDTH  32  Timestamp counter width (clk cycles); record = {timestamp, status_word}
// PORTS
//   clk            in   1             System clock
//   n_rst          in   1             Synchronous reset, active low
//   status_word    in   32            Status word from hardware manager
//   ps_interrupt   in   1             Event strobe from hardware manager
//   irq_en         in   1             IRQ enable
//   rd_en          in   1             Pop strobe from PS (one entry per high cycle)
//   clr_overflow   in   1             Clears overflow and drop_count
//   rd_data        out  TS_WIDTH+32   FIFO head {timestamp, status_word}; valid when rd_valid
//   rd_valid       out  1             FIFO non-empty
//   entry_count    out  log2(DEPTH)+1 Number of queued entries, 0..DEPTH
//   overflow       out  1             Sticky: an event was dropped because the FIFO was full
//   drop_count     out  16            Dropped events, saturates at 16'hFFFF
//   last_status    out  32            status_word of the most recent event, accepted or dropped
//   irq            out  1             Registered: irq_en && (FIFO non-empty || overflow)
// BEHAVIOUR
//   - Reset: n_rst sampled low on a clk edge clears all of the following:
//     - timestamp = 0, FIFO empty, rd_valid = 0, entry_count = 0
//     - rd_data = 0, overflow = 0, drop_count = 0, last_status = 0, irq = 0
//     - edge-detect register = 0
//   - Reset mid-operation: all queued entries are discarded, with no partial state.
//   - Timestamp: free-running, increments every cycle, wraps 2^TS_WIDTH-1 -> 0.
//   - Event detection:
//     - An event is the rising edge of ps_interrupt: ps_interrupt=1 and the previous
//       cycle's value was 0.
//     - A level held high for N cycles is exactly one event.
//     - ps_interrupt high in the first cycle after reset counts as an event.
//   - Capture:
//     - At the event cycle T, the record is {timestamp(T), status_word(T)}.
//     - Write happens on the edge ending T. rd_valid, rd_data and entry_count reflect it
//       from T+1.
//     - last_status <= status_word(T) at the same edge.
//   - Read (FWFT):
//     - rd_data always shows the head while rd_valid=1.
//     - rd_en=1 with rd_valid=1 pops on that edge; the next entry is visible the
//       following cycle.
//     - rd_en with empty FIFO is ignored: no pointer change, no error.
//     - rd_data holds its last value when empty.
//   - Full:
//     - An event with entry_count==DEPTH and no simultaneous pop is dropped.
//     - On a drop: overflow <= 1 and drop_count += 1 (saturating); FIFO contents are
//       unchanged.
//   - Simultaneous push and pop:
//     - When full, the pop frees the slot and the push is accepted; count stays DEPTH,
//       no drop.
//     - When 1 entry, the pop and push both occur; count stays 1, and the head becomes
//       the new record.
//   - clr_overflow:
//     - Clears overflow and drop_count on that edge.
//     - A drop in the same cycle wins: overflow=1, drop_count=1.
//   - Pointers: log2(DEPTH) bits, wrap naturally; entry_count is tracked separately.
//   - irq: registered, 1-cycle latency from the state it reflects; deasserts the cycle
//     after the last pop (if overflow=0) or after irq_en falls.
//   - Widths: all arithmetic is unsigned, and there are no signed compares.
// TESTING
//   1. Reset, then ps_interrupt 1-cycle pulse with status_word=32'h0000_0025 at
//      timestamp 100 -> next cycle rd_valid=1, entry_count=1,
//      rd_data={32'd100, 32'h25}, irq=1 (irq_en=1).
//   2. Hold ps_interrupt high 10 cycles -> exactly one entry. Pop with rd_en ->
//      rd_valid=0, entry_count=0, irq=0 one cycle later.
//   3. DEPTH=16: 20 separated pulses, no reads -> entry_count=16, overflow=1,
//      drop_count=4, last_status = 20th word. Entries 1..16 read back in order.
//   4. FIFO full, event and rd_en in the same cycle -> entry_count stays 16,
//      drop_count unchanged, and the new record appears at the tail.
//   5. clr_overflow together with a drop event -> overflow=1, drop_count=1.
//      clr_overflow alone -> overflow=0, drop_count=0.
//   6. n_rst low for 1 cycle with 5 entries queued -> all outputs 0. A subsequent event
//      timestamps from the restarted counter.

Source files
------------

// File: rtl/hw_status_logger.sv
// hw_status_logger: timestamps each rising edge of ps_interrupt and queues
// {timestamp, status_word} in a first-word-fall-through FIFO for the PS to
// pop. It also provides a level irq, a sticky overflow flag, a saturating
// drop counter, and the last status word seen.
module hw_status_logger #(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [31:0]               status_word,
  input  logic                      ps_interrupt,
  input  logic                      irq_en,
  input  logic                      rd_en,
  input  logic                      clr_overflow,
  output logic [TS_WIDTH+31:0]      rd_data,
  output logic                      rd_valid,
  output logic [$clog2(DEPTH):0]    entry_count,
  output logic                      overflow,
  output logic [15:0]               drop_count,
  output logic [31:0]               last_status,
  output logic                      irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_WIDTH + 32;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                prev_q, prev_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [RW-1:0]       rd_data_q, rd_data_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         drop_q, drop_d;
  logic [31:0]         last_q, last_d;
  logic                irq_q, irq_d;
  logic [RW-1:0]       mem_q [DEPTH];

  logic          evt, pop, push, drop, full;
  logic [RW-1:0] new_rec;

  // Event detect, FIFO bookkeeping, and next head / status computation.
  always_comb begin
    evt     = ps_interrupt & ~prev_q;
    full    = (count_q == FULL_CNT);
    pop     = rd_en && (count_q != '0);
    // When full, a same-cycle pop frees the slot for the incoming record.
    push    = evt && (!full || pop);
    drop    = evt && full && !pop;
    new_rec = {ts_q, status_word};

    ts_d     = ts_q + TS_WIDTH'(1);
    prev_d   = ps_interrupt;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);

    // rd_data is registered so that it holds when the FIFO is empty. The
    // next head is the record being written this cycle whenever that record
    // lands in the slot the read pointer will point to.
    rd_data_d = rd_data_q;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) rd_data_d = new_rec;
      else                                rd_data_d = mem_q[rd_ptr_d];
    end

    // A drop in the same cycle as clr_overflow takes priority over the clear.
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_overflow)            drop_d = 16'd1;
      else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_d     = 16'd0;
    end

    last_d = evt ? status_word : last_q;
    irq_d  = irq_en && ((count_d != '0) || overflow_d);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ts_q       <= '0;
      prev_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      last_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      last_q     <= last_d;
      irq_q      <= irq_d;
    end
  end

  // FIFO storage. Reset leaves it alone because resetting the pointers
  // already discards every queued entry.
  always_ff @(posedge clk) begin
    if (n_rst && push) mem_q[wr_ptr_q] <= new_rec;
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = (count_q != '0);
  assign entry_count = count_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;
  assign last_status = last_q;
  assign irq         = irq_q;
endmodule

// File: tb/tb_hw_status_logger.sv
// Bench for hw_status_logger (DEPTH=16, TS_WIDTH=32).
module tb_hw_status_logger;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] status_word = '0;
  logic        ps_interrupt = 1'b0, irq_en = 1'b1, rd_en = 1'b0, clr_overflow = 1'b0;
  logic [63:0] rd_data;
  logic        rd_valid, overflow, irq;
  logic [4:0]  entry_count;
  logic [15:0] drop_count;
  logic [31:0] last_status;

  int n_chk = 0, n_fail = 0;

  hw_status_logger #(.DEPTH(16), .TS_WIDTH(32)) dut (
    .clk(clk), .n_rst(n_rst), .status_word(status_word), .ps_interrupt(ps_interrupt),
    .irq_en(irq_en), .rd_en(rd_en), .clr_overflow(clr_overflow), .rd_data(rd_data),
    .rd_valid(rd_valid), .entry_count(entry_count), .overflow(overflow),
    .drop_count(drop_count), .last_status(last_status), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [63:0] mq[$];
  logic [31:0] m_ts;
  logic        m_prev, m_ovf;
  logic [15:0] m_drop;
  logic [31:0] m_last;
  logic [63:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, and sample 1 ns later.
  task automatic cyc(input logic ps, input logic [31:0] st, input logic rd, input logic clr);
    logic ev, pop, full, drop;
    ps_interrupt = ps; status_word = st; rd_en = rd; clr_overflow = clr;
    @(posedge clk);
    if (!n_rst) begin
      mq.delete(); m_ts = 0; m_prev = 0; m_ovf = 0; m_drop = 0; m_last = 0; m_data = 0;
    end else begin
      ev   = ps && !m_prev;
      full = (mq.size() == 16);
      pop  = rd && (mq.size() != 0);
      drop = ev && full && !pop;
      if (pop) void'(mq.pop_front());
      if (ev && !drop) mq.push_back({m_ts, st});
      if (drop) begin
        m_ovf = 1;
        m_drop = clr ? 16'd1 : (m_drop == 16'hFFFF ? m_drop : m_drop + 16'd1);
      end else if (clr) begin
        m_ovf = 0; m_drop = 0;
      end
      if (ev) m_last = st;
      m_prev = ps;
      m_ts = m_ts + 1;
      if (mq.size() != 0) m_data = mq[0];
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, 64'(rd_valid), 64'(mq.size() != 0));
    chk({tag, ".count"}, 64'(entry_count), 64'(mq.size()));
    chk({tag, ".data"}, rd_data, m_data);
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".drops"}, 64'(drop_count), 64'(m_drop));
    chk({tag, ".last"}, 64'(last_status), 64'(m_last));
    chk({tag, ".irq"}, 64'(irq), 64'(irq_en && (mq.size() != 0 || m_ovf)));
  endtask

  typedef struct {
    logic        ps;
    logic [31:0] st;
    logic        rd;
    logic        ie;
    logic        e_valid;
    logic [4:0]  e_cnt;
    logic        e_irq;
    logic [31:0] e_last;
    logic [63:0] e_data;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Hand-computed sequence. Timestamp t is current in the t-th cycle after reset.
    tbl[0]  = '{1, 32'h25, 0, 1, 1, 5'd1, 1, 32'h25, {32'd100, 32'h25}}; // ts 100
    tbl[1]  = '{0, 32'h0,  0, 1, 1, 5'd1, 1, 32'h25, {32'd100, 32'h25}};
    tbl[2]  = '{1, 32'h77, 0, 1, 1, 5'd2, 1, 32'h77, {32'd100, 32'h25}}; // ts 102
    for (int i = 3; i < 12; i++)  // level held: no further events
      tbl[i] = '{1, 32'hDEAD, 0, 1, 1, 5'd2, 1, 32'h77, {32'd100, 32'h25}};
    tbl[12] = '{0, 32'h0,  1, 1, 1, 5'd1, 1, 32'h77, {32'd102, 32'h77}};
    tbl[13] = '{0, 32'h0,  1, 1, 0, 5'd0, 0, 32'h77, {32'd102, 32'h77}};
    tbl[14] = '{0, 32'h0,  1, 1, 0, 5'd0, 0, 32'h77, {32'd102, 32'h77}}; // pop on empty
    tbl[15] = '{1, 32'h55, 0, 0, 1, 5'd1, 0, 32'h55, {32'd115, 32'h55}}; // irq_en off
    tbl[16] = '{0, 32'h0,  0, 1, 1, 5'd1, 1, 32'h55, {32'd115, 32'h55}};

    // Reset state.
    n_rst = 0; cyc(0, 0, 0, 0); n_rst = 1;
    chk_model("reset");
    chk("reset.data0", rd_data, 64'd0);
    for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0);

    // Table-driven vectors: single event, held level, pops, and irq_en gating.
    for (int i = 0; i < 17; i++) begin
      irq_en = tbl[i].ie;
      cyc(tbl[i].ps, tbl[i].st, tbl[i].rd, 0);
      chk($sformatf("vec%0d.valid", i), 64'(rd_valid), 64'(tbl[i].e_valid));
      chk($sformatf("vec%0d.count", i), 64'(entry_count), 64'(tbl[i].e_cnt));
      chk($sformatf("vec%0d.irq", i), 64'(irq), 64'(tbl[i].e_irq));
      chk($sformatf("vec%0d.last", i), 64'(last_status), 64'(tbl[i].e_last));
      chk($sformatf("vec%0d.data", i), rd_data, tbl[i].e_data);
    end
    irq_en = 1;

    // Overflow: 20 separated pulses with no reads.
    n_rst = 0; cyc(0, 0, 0, 0); n_rst = 1;
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 32'hA000_0000 + i, 0, 0);
      chk_model($sformatf("fill%0d", i));
      cyc(0, 0, 0, 0);
    end
    chk("ovf.count", 64'(entry_count), 64'd16);
    chk("ovf.flag", 64'(overflow), 64'd1);
    chk("ovf.drops", 64'(drop_count), 64'd4);
    chk("ovf.last", 64'(last_status), 64'hA000_0014);
    chk("ovf.head", 64'(rd_data[31:0]), 64'hA000_0001);

    // Full FIFO: an event and a pop in the same cycle are both accepted.
    cyc(1, 32'h0000_BEEF, 1, 0);
    chk("fullpp.count", 64'(entry_count), 64'd16);
    chk("fullpp.drops", 64'(drop_count), 64'd4);
    chk_model("fullpp");
    cyc(0, 0, 0, 0);
    for (int i = 2; i <= 17; i++) begin
      chk($sformatf("drain%0d.word", i), 64'(rd_data[31:0]),
          (i == 17) ? 64'h0000_BEEF : 64'(32'hA000_0000 + i));
      cyc(0, 0, 1, 0);
      chk_model($sformatf("drain%0d", i));
    end

    // One queued entry: a pop and push in the same cycle make the new record the head.
    cyc(1, 32'h0000_0111, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 32'h0000_0222, 1, 0);
    chk("one.count", 64'(entry_count), 64'd1);
    chk("one.head", 64'(rd_data[31:0]), 64'h0000_0222);
    chk_model("one");
    cyc(0, 0, 1, 0);

    // clr_overflow in the same cycle as a drop, then clr_overflow alone.
    for (int i = 0; i < 16; i++) begin cyc(1, 32'hC000_0000 + i, 0, 0); cyc(0, 0, 0, 0); end
    cyc(1, 32'h0000_D00D, 0, 1);
    chk("clrdrop.ovf", 64'(overflow), 64'd1);
    chk("clrdrop.drops", 64'(drop_count), 64'd1);
    cyc(0, 0, 0, 1);
    chk("clr.ovf", 64'(overflow), 64'd0);
    chk("clr.drops", 64'(drop_count), 64'd0);
    chk_model("clr");

    // Reset with 5 entries queued, then an event in the first cycle after reset.
    for (int i = 0; i < 11; i++) cyc(0, 0, 1, 0);
    chk("pre_rst.count", 64'(entry_count), 64'd5);
    n_rst = 0; cyc(0, 0, 0, 0); n_rst = 1;
    chk("rst.count", 64'(entry_count), 64'd0);
    chk("rst.data", rd_data, 64'd0);
    chk("rst.irq", 64'(irq), 64'd0);
    chk("rst.last", 64'(last_status), 64'd0);
    chk_model("rst");
    cyc(1, 32'h0000_0042, 0, 0);
    chk("postrst.data", rd_data, {32'd0, 32'h42});
    chk_model("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
